// File: rtl/write_path_pkg.sv
// Shared definitions for the SRAM write path: ingress FSM encoding and
// default widths reused by the port buffers and the write arbiter.
package write_path_pkg;

  localparam int unsigned DATA_WIDTH_DEF     = 32;
  localparam int unsigned PRIORITY_WIDTH_DEF = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RECV = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinationally visible head entry.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] head_c,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push_c, do_pop_c;

  always_comb begin
    do_pop_c  = pop && (count_q != '0);
    do_push_c = push && ((count_q != CW'(DEPTH)) || do_pop_c);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (do_push_c) begin
      wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
    end
    if (do_pop_c) begin
      rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
    end
    case ({do_push_c, do_pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_c) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  assign head_c = mem[rd_ptr_q];
  assign full   = full_q;
  assign empty  = empty_q;

endmodule

// File: rtl/ingress_port_buffer.sv
// Per-port ingress packet buffer: stores whole packets, exposes only
// committed packets to the arbiter, and drops oversize/broken packets atomically.
module ingress_port_buffer
  import write_path_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned META_DEPTH     = 16,
  parameter int unsigned PRIORITY_WIDTH = PRIORITY_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_sop,
  input  logic                      wr_eop,
  input  logic                      wr_vld,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      rd_en,
  output logic                      ready,
  output logic [PRIORITY_WIDTH-1:0] priority_out,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_vld,
  output logic                      eop_out,
  output logic                      drop
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned PW    = ADDR_WIDTH + 1;
  localparam int unsigned CW    = $clog2(META_DEPTH + 1);
  localparam int unsigned EW    = DATA_WIDTH + 1;

  logic [EW-1:0] mem [DEPTH];

  logic [1:0]                state_q, state_d;
  logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]             commit_ptr_q, commit_ptr_d;
  logic [PRIORITY_WIDTH-1:0] prio_q, prio_d;
  logic [CW-1:0]             pkt_cnt_q, pkt_cnt_d;

  logic                      ready_q, ready_d;
  logic [PRIORITY_WIDTH-1:0] priority_out_q, priority_out_d;
  logic [DATA_WIDTH-1:0]     rd_data_q, rd_data_d;
  logic                      rd_vld_q, rd_vld_d;
  logic                      eop_out_q, eop_out_d;
  logic                      drop_q, drop_d;

  logic [PW-1:0]             wr_base_c, wr_occ_c, sop_occ_c;
  logic [PRIORITY_WIDTH-1:0] commit_prio_c, meta_head_c;
  logic [EW-1:0]             rd_word_c;
  logic                      wr_en_c, commit_c, start_sop_c, pop_c, eop_pop_c;
  logic                      meta_full, meta_empty;

  // Write FSM; a refused or broken packet rewinds wr_ptr to the last commit.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    commit_ptr_d  = commit_ptr_q;
    prio_d        = prio_q;
    drop_d        = 1'b0;
    wr_en_c       = 1'b0;
    commit_c      = 1'b0;
    start_sop_c   = 1'b0;
    wr_base_c     = wr_ptr_q;
    commit_prio_c = prio_q;
    wr_occ_c      = wr_ptr_q - rd_ptr_q;

    case (state_q)
      ST_IDLE: start_sop_c = wr_vld && wr_sop;
      ST_RECV: begin
        if (wr_vld) begin
          if (wr_sop) begin
            wr_base_c   = commit_ptr_q;
            wr_ptr_d    = commit_ptr_q;
            drop_d      = 1'b1;
            start_sop_c = 1'b1;
          end else if (wr_occ_c == PW'(DEPTH)) begin
            wr_ptr_d = commit_ptr_q;
            drop_d   = 1'b1;
            state_d  = wr_eop ? ST_IDLE : ST_DROP;
          end else begin
            wr_en_c  = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (wr_eop) begin
              commit_ptr_d = wr_ptr_q + PW'(1);
              commit_c     = 1'b1;
              state_d      = ST_IDLE;
            end
          end
        end
      end
      ST_DROP: begin
        if (wr_vld) begin
          if (wr_sop) begin
            start_sop_c = 1'b1;
          end else if (wr_eop) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Space for a new packet is judged against committed data only.
    sop_occ_c = wr_base_c - rd_ptr_q;
    if (start_sop_c) begin
      if ((pkt_cnt_q == CW'(META_DEPTH)) || meta_full || (sop_occ_c == PW'(DEPTH))) begin
        drop_d  = 1'b1;
        state_d = wr_eop ? ST_IDLE : ST_DROP;
      end else begin
        wr_en_c  = 1'b1;
        wr_ptr_d = wr_base_c + PW'(1);
        prio_d   = wr_data[PRIORITY_WIDTH-1:0];
        if (wr_eop) begin
          commit_ptr_d  = wr_base_c + PW'(1);
          commit_c      = 1'b1;
          commit_prio_c = wr_data[PRIORITY_WIDTH-1:0];
          state_d       = ST_IDLE;
        end else begin
          state_d = ST_RECV;
        end
      end
    end
  end

  // Read side: only committed words can be popped.
  always_comb begin
    rd_word_c = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
    pop_c     = rd_en && (rd_ptr_q != commit_ptr_q);
    eop_pop_c = pop_c && rd_word_c[DATA_WIDTH];
    rd_ptr_d  = rd_ptr_q + PW'(pop_c);
    case ({commit_c, eop_pop_c})
      2'b10:   pkt_cnt_d = pkt_cnt_q + CW'(1);
      2'b01:   pkt_cnt_d = pkt_cnt_q - CW'(1);
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
    rd_data_d      = pop_c ? rd_word_c[DATA_WIDTH-1:0] : '0;
    rd_vld_d       = pop_c;
    eop_out_d      = eop_pop_c;
    ready_d        = (pkt_cnt_q != '0);
    priority_out_d = meta_empty ? '0 : meta_head_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      commit_ptr_q   <= '0;
      prio_q         <= '0;
      pkt_cnt_q      <= '0;
      ready_q        <= 1'b0;
      priority_out_q <= '0;
      rd_data_q      <= '0;
      rd_vld_q       <= 1'b0;
      eop_out_q      <= 1'b0;
      drop_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      commit_ptr_q   <= commit_ptr_d;
      prio_q         <= prio_d;
      pkt_cnt_q      <= pkt_cnt_d;
      ready_q        <= ready_d;
      priority_out_q <= priority_out_d;
      rd_data_q      <= rd_data_d;
      rd_vld_q       <= rd_vld_d;
      eop_out_q      <= eop_out_d;
      drop_q         <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wr_base_c[ADDR_WIDTH-1:0]] <= {wr_eop, wr_data};
    end
  end

  sync_fifo #(
    .WIDTH (PRIORITY_WIDTH),
    .DEPTH (META_DEPTH)
  ) u_meta_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (commit_c),
    .pop     (eop_pop_c),
    .wr_data (commit_prio_c),
    .head_c  (meta_head_c),
    .full    (meta_full),
    .empty   (meta_empty)
  );

  assign ready        = ready_q;
  assign priority_out = priority_out_q;
  assign rd_data      = rd_data_q;
  assign rd_vld       = rd_vld_q;
  assign eop_out      = eop_out_q;
  assign drop         = drop_q;

endmodule

// File: tb/tb_ingress_port_buffer.sv
// Bench for ingress_port_buffer: directed scenarios plus random traffic,
// checked every cycle against a packet-level queue model.
module tb_ingress_port_buffer;

  localparam int DEPTH = 256;
  localparam int META  = 16;

  logic        clk = 1'b0;
  logic        rst, wr_sop, wr_eop, wr_vld, rd_en;
  logic [31:0] wr_data;
  logic        ready, rd_vld, eop_out, drop;
  logic [2:0]  priority_out;
  logic [31:0] rd_data;

  always #5 clk = ~clk;

  ingress_port_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .wr_sop       (wr_sop),
    .wr_eop       (wr_eop),
    .wr_vld       (wr_vld),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .ready        (ready),
    .priority_out (priority_out),
    .rd_data      (rd_data),
    .rd_vld       (rd_vld),
    .eop_out      (eop_out),
    .drop         (drop)
  );

  typedef struct {
    bit          rst;
    bit          vld;
    bit          sop;
    bit          eop;
    bit          rd;
    logic [31:0] data;
  } stim_t;

  stim_t stim[$];
  int total = 0;
  int bad   = 0;

  // Reference model: committed words, committed priorities, packet in flight.
  logic [32:0] cq[$];
  logic [2:0]  pq[$];
  logic [32:0] cur[$];
  logic [2:0]  cur_prio;
  bit          in_pkt;
  bit          e_ready, e_rvld, e_eop, e_drop;
  logic [2:0]  e_prio;
  logic [31:0] e_data;

  task automatic model_commit();
    foreach (cur[i]) cq.push_back(cur[i]);
    pq.push_back(cur_prio);
    cur.delete();
    in_pkt = 0;
  endtask

  task automatic model_step(input stim_t s);
    int ncw, npk;
    logic [32:0] w;
    logic [2:0]  pd;
    if (s.rst) begin
      cq.delete(); pq.delete(); cur.delete(); in_pkt = 0;
      e_ready = 0; e_prio = 0; e_rvld = 0; e_eop = 0; e_drop = 0; e_data = 0;
      return;
    end
    ncw = cq.size();
    npk = pq.size();
    e_ready = (npk != 0);
    e_prio  = (npk != 0) ? pq[0] : 3'd0;
    e_rvld = 0; e_eop = 0; e_data = 0; e_drop = 0;
    if (s.rd && ncw != 0) begin
      w = cq.pop_front();
      e_rvld = 1; e_eop = w[32]; e_data = w[31:0];
      if (w[32]) pd = pq.pop_front();
    end
    if (s.vld && s.sop) begin
      if (in_pkt) begin
        e_drop = 1; cur.delete(); in_pkt = 0;
      end
      if (npk == META || ncw == DEPTH) begin
        e_drop = 1;
      end else begin
        cur.push_back({s.eop, s.data});
        cur_prio = s.data[2:0];
        in_pkt = 1;
        if (s.eop) model_commit();
      end
    end else if (s.vld && in_pkt) begin
      if (ncw + cur.size() == DEPTH) begin
        e_drop = 1; cur.delete(); in_pkt = 0;
      end else begin
        cur.push_back({s.eop, s.data});
        if (s.eop) model_commit();
      end
    end
  endtask

  function automatic logic [38:0] exp_vec();
    return {e_ready, e_prio, e_rvld, e_eop, e_drop, e_data};
  endfunction

  function automatic logic [38:0] obs_vec();
    return {ready, priority_out, rd_vld, eop_out, drop, (e_rvld ? rd_data : 32'h0)};
  endfunction

  function automatic void add(bit r, bit v, bit s, bit e, bit rd, logic [31:0] d);
    stim_t t;
    t.rst = r; t.vld = v; t.sop = s; t.eop = e; t.rd = rd; t.data = d;
    stim.push_back(t);
  endfunction

  function automatic void add_pkt(int len, logic [2:0] prio, bit rd);
    for (int i = 0; i < len; i++) begin
      logic [31:0] d;
      d = $urandom;
      if (i == 0) d[2:0] = prio;
      add(0, 1, i == 0, i == len - 1, rd, d);
    end
  endfunction

  function automatic void add_idle(int n, bit rd);
    for (int i = 0; i < n; i++) add(0, 0, 0, 0, rd, $urandom);
  endfunction

  task automatic cycle(input stim_t s);
    rst = s.rst; wr_vld = s.vld; wr_sop = s.sop; wr_eop = s.eop;
    wr_data = s.data; rd_en = s.rd;
    model_step(s);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    stim.delete();
    add(1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0);
    foreach (stim[i]) begin
      cycle(stim[i]);
      total++;
      if ({ready, priority_out, rd_data, rd_vld, eop_out, drop} !== 39'h0) begin
        bad++;
        $display("FAIL reset cyc=%0d got=%h want=0", i,
                 {ready, priority_out, rd_data, rd_vld, eop_out, drop});
      end
    end
  endtask

  task automatic test_basic();
    int nw = 0, ne = 0;
    stim.delete();
    add_pkt(4, 3'd5, 0); add_idle(2, 0); add_idle(4, 1); add_idle(3, 0);
    foreach (stim[i]) begin
      cycle(stim[i]);
      nw += int'(rd_vld); ne += int'(eop_out);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL basic cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
    total++;
    if (nw != 4 || ne != 1) begin
      bad++;
      $display("FAIL basic_counts got words=%0d eops=%0d want 4/1", nw, ne);
    end
  endtask

  task automatic test_single();
    stim.delete();
    add_pkt(1, 3'd2, 0); add_idle(2, 0); add_idle(1, 1); add_idle(3, 0);
    foreach (stim[i]) begin
      cycle(stim[i]);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL single cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_overflow();
    int nd = 0;
    stim.delete();
    add_pkt(260, 3'd7, 0); add_idle(2, 0); add_pkt(3, 3'd4, 0);
    add_idle(2, 0); add_idle(5, 1); add_idle(2, 0);
    foreach (stim[i]) begin
      cycle(stim[i]);
      nd += int'(drop);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL overflow cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
    total++;
    if (nd != 1) begin
      bad++;
      $display("FAIL overflow_drops got=%0d want=1", nd);
    end
  endtask

  task automatic test_missing_eop();
    stim.delete();
    add(0, 1, 1, 0, 0, 32'hAAAA_0001);
    add(0, 1, 0, 0, 0, $urandom);
    add(0, 1, 0, 0, 0, $urandom);
    add_pkt(3, 3'd6, 0); add_idle(2, 0); add_idle(5, 1); add_idle(2, 0);
    foreach (stim[i]) begin
      cycle(stim[i]);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL missing_eop cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_meta_full();
    int nd = 0, ne = 0;
    stim.delete();
    for (int p = 0; p < META; p++) add_pkt(1, 3'(p), 0);
    add_pkt(1, 3'd3, 0);
    add_idle(2, 0);
    add_idle(2, 1);
    add_pkt(3, 3'd1, 1);
    add_idle(20, 1); add_idle(2, 0);
    foreach (stim[i]) begin
      cycle(stim[i]);
      nd += int'(drop); ne += int'(eop_out);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL meta_full cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
    total++;
    if (nd != 1 || ne != META + 1) begin
      bad++;
      $display("FAIL meta_counts got drops=%0d eops=%0d want 1/%0d", nd, ne, META + 1);
    end
  endtask

  task automatic test_empty_read();
    int nv = 0;
    stim.delete();
    add_idle(4, 1);
    add_pkt(2, 3'd1, 0); add_idle(2, 0); add_idle(3, 1); add_idle(2, 0);
    foreach (stim[i]) begin
      cycle(stim[i]);
      if (i < 4) nv += int'(rd_vld);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL empty_read cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
    total++;
    if (nv != 0) begin
      bad++;
      $display("FAIL empty_rd_vld got=%0d want=0", nv);
    end
  endtask

  task automatic test_rst_mid();
    stim.delete();
    add_pkt(2, 3'd3, 0);
    add(0, 1, 1, 0, 0, $urandom);
    add(0, 1, 0, 0, 1, $urandom);
    add(1, 1, 0, 0, 1, $urandom);
    add(0, 1, 0, 1, 1, $urandom);
    add_idle(4, 1);
    foreach (stim[i]) begin
      cycle(stim[i]);
      total++;
      if (stim[i].rst) begin
        if ({ready, priority_out, rd_data, rd_vld, eop_out, drop} !== 39'h0) begin
          bad++;
          $display("FAIL rst_mid got=%h want=0",
                   {ready, priority_out, rd_data, rd_vld, eop_out, drop});
        end
      end else if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL rst_mid cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    int pct;
    stim.delete();
    for (int ph = 0; ph < 4; ph++) begin
      pct = (ph == 0) ? 0 : (ph == 1) ? 25 : (ph == 2) ? 90 : 100;
      for (int c = 0; c < 1500; c++) begin
        add(0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 99) < pct, $urandom);
      end
    end
    add_idle(300, 1);
    foreach (stim[i]) begin
      cycle(stim[i]);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL random cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    rst = 1'b1; wr_vld = 1'b0; wr_sop = 1'b0; wr_eop = 1'b0;
    wr_data = '0; rd_en = 1'b0;
    in_pkt = 0;
    e_ready = 0; e_prio = 0; e_rvld = 0; e_eop = 0; e_drop = 0; e_data = 0;
    test_reset();
    test_basic();
    test_single();
    test_overflow();
    test_missing_eop();
    test_meta_full();
    test_empty_read();
    test_rst_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
